// File: rtl/joiner_stream_arbiter.sv
// Two-requester arbiter that lends one intersect_unit to A or B for a whole job,
// forwarding the owner's four lanes combinationally and timing each job.
module joiner_stream_arbiter #(
  parameter int                DATA_W     = 17,
  parameter logic [DATA_W-1:0] DONE_TOKEN = 17'h10100,
  parameter int                NUM_LANES  = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clk_en,
  input  logic                        flush,
  input  logic [DATA_W*NUM_LANES-1:0] a_data,
  input  logic [NUM_LANES-1:0]        a_valid,
  output logic [NUM_LANES-1:0]        a_ready,
  input  logic [DATA_W*NUM_LANES-1:0] b_data,
  input  logic [NUM_LANES-1:0]        b_valid,
  output logic [NUM_LANES-1:0]        b_ready,
  output logic [DATA_W*NUM_LANES-1:0] out_data,
  output logic [NUM_LANES-1:0]        out_valid,
  input  logic [NUM_LANES-1:0]        out_ready,
  input  logic [DATA_W-1:0]           mon_data,
  input  logic                        mon_valid,
  input  logic                        mon_ready,
  output logic                        grant_valid,
  output logic                        grant_id,
  output logic                        job_done,
  output logic [31:0]                 job_cycles
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t                 state_q, state_d;
  logic                   grant_id_q, grant_id_d;
  logic                   prio_q, prio_d;
  logic [NUM_LANES-1:0]   lane_done_q, lane_done_d;
  logic [31:0]            cnt_q, cnt_d;
  logic [31:0]            job_cycles_q, job_cycles_d;
  logic                   job_done_q, job_done_d;

  logic [DATA_W*NUM_LANES-1:0] sel_data;
  logic [NUM_LANES-1:0]        sel_valid;
  logic [NUM_LANES-1:0]        lane_open;
  logic [NUM_LANES-1:0]        lane_fire;
  logic [NUM_LANES-1:0]        lane_is_done;
  logic                        run_active;
  logic                        mon_done;
  logic                        req_a, req_b;
  logic [31:0]                 cnt_inc;

  assign sel_data   = grant_id_q ? b_data  : a_data;
  assign sel_valid  = grant_id_q ? b_valid : a_valid;
  assign run_active = clk_en && (state_q == S_RUN);
  assign lane_open  = {NUM_LANES{run_active}} & ~lane_done_q;

  assign out_data   = sel_data;
  assign out_valid  = sel_valid & lane_open;
  assign a_ready    = grant_id_q ? '0 : (out_ready & lane_open);
  assign b_ready    = grant_id_q ? (out_ready & lane_open) : '0;
  assign lane_fire  = out_valid & out_ready;

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    assign lane_is_done[gi] = (sel_data[gi*DATA_W +: DATA_W] == DONE_TOKEN);
  end

  assign mon_done = mon_valid && mon_ready && (mon_data == DONE_TOKEN);
  assign req_a    = |a_valid;
  assign req_b    = |b_valid;
  assign cnt_inc  = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;

  assign grant_valid = (state_q != S_IDLE);
  assign grant_id    = grant_id_q;
  assign job_done    = job_done_q;
  assign job_cycles  = job_cycles_q;

  always_comb begin
    state_d      = state_q;
    grant_id_d   = grant_id_q;
    prio_d       = prio_q;
    lane_done_d  = lane_done_q;
    cnt_d        = cnt_q;
    job_cycles_d = job_cycles_q;
    job_done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_a || req_b) begin
          state_d     = S_RUN;
          grant_id_d  = (req_a && req_b) ? prio_q : req_b;
          lane_done_d = '0;
          cnt_d       = 32'd1;
        end
      end
      S_RUN: begin
        cnt_d       = cnt_inc;
        lane_done_d = lane_done_q | (lane_fire & lane_is_done);
        if (&lane_done_d) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        cnt_d = cnt_inc;
        // Only a done token on the joiner's output closes the job.
        if (mon_done) begin
          job_cycles_d = cnt_q;
          job_done_d   = 1'b1;
          prio_d       = ~grant_id_q;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      state_d      = S_IDLE;
      grant_id_d   = 1'b0;
      prio_d       = 1'b0;
      lane_done_d  = '0;
      cnt_d        = '0;
      job_cycles_d = '0;
      job_done_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      grant_id_q   <= 1'b0;
      prio_q       <= 1'b0;
      lane_done_q  <= '0;
      cnt_q        <= '0;
      job_cycles_q <= '0;
      job_done_q   <= 1'b0;
    end else if (clk_en || flush) begin
      state_q      <= state_d;
      grant_id_q   <= grant_id_d;
      prio_q       <= prio_d;
      lane_done_q  <= lane_done_d;
      cnt_q        <= cnt_d;
      job_cycles_q <= job_cycles_d;
      job_done_q   <= job_done_d;
    end
  end

endmodule
